uart_autobaud_ctrl: RTL and testbench
=====================================

Name: uart_autobaud_ctrl

Overview:
Configuration controller that owns the 32-bit `baudrate_division` word feeding the UART clock divider.
- The divider toggles `div_clk` every (N+1) CLK cycles, so one `div_clk` period (one bit time) is 2·(N+1) CLK cycles.
- The word is loaded either by a software write or by autobaud measurement of a received 0x55 ('U') character on the RX line.
- The block sits between the UART register interface and the divider, and guarantees that the divider never sees a divisor below `MIN_DIV`.

Parameters:
- SYNC_STAGES, 2: RX synchronizer depth (≥2).
- RESET_DIV, 216: `baudrate_division` value after reset (50 MHz CLK, 115200 baud).
- MIN_DIV, 3: smallest divisor ever driven; smaller values are clamped or flagged.
- TIMEOUT, 32'd50000000: maximum CLK cycles allowed in ARM+MEASURE before an error.

Ports:
- CLK  in  1  system clock; single clock domain.
- HRESET  in  1  asynchronous, active-low reset.
- rx  in  1  raw UART RX line, asynchronous; idle level is high.
- sw_div_wr  in  1  one-cycle software write strobe.
- sw_div  in  32  software divisor value.
- autobaud_start  in  1  one-cycle request to measure the next 0x55 character.
- baudrate_division  out  32  divisor driven to the clock divider.
- autobaud_busy  out  1  high while in ARM or MEASURE.
- autobaud_done  out  1  one-cycle pulse when a measured divisor is applied.
- autobaud_err  out  1  sticky error flag; cleared by the next `autobaud_start` or `sw_div_wr`.

Behaviour:
- Reset (async, HRESET=0):
  - `baudrate_division`=RESET_DIV; `autobaud_busy`=0; `autobaud_done`=0; `autobaud_err`=0.
  - State=IDLE; cycle counter=0; edge counter=0.
  - Synchronizer flops reset to 1 (idle line).
- RX input: passed through a SYNC_STAGES flop chain, then one extra flop for edge detection. A falling edge is prev=1 and cur=0, both taken from the synchronized domain.
- Software write:
  - On `sw_div_wr`=1, `baudrate_division` takes max(`sw_div`, MIN_DIV) on the next edge.
  - `autobaud_err` clears on the same edge.
  - The write wins over any autobaud activity: it aborts ARM/MEASURE, returns to IDLE and drops busy, with no done pulse and no error.
- State machine:
  - IDLE: on `autobaud_start`=1 (and `sw_div_wr`=0), go to WAIT_HIGH. Set busy=1, clear err, cycle counter=0.
  - WAIT_HIGH: stay until the synchronized rx=1. This prevents arming mid-character. Then go to ARM.
  - ARM: on a falling edge (start bit), go to MEASURE. Set cycle counter=0 and edge counter=1.
  - MEASURE: cycle counter increments every CLK cycle. Each falling edge increments the edge counter. On the 5th falling edge (start bit plus data bits 1, 3, 5, 7 of 0x55), the current cycle count T8 spans exactly 8 bit times; compute div = ((T8+8)>>4)−1.
    - If div ≥ MIN_DIV: on the next edge, `baudrate_division`=div, `autobaud_done` pulses for 1 cycle, busy=0, state returns to IDLE.
    - Otherwise: `autobaud_err`=1, busy=0, IDLE, and `baudrate_division` is unchanged.
  - The rising edge of the stop bit is not checked.
- Timeout: a separate counter runs in WAIT_HIGH, ARM and MEASURE. When it reaches TIMEOUT, set err=1, busy=0 and return to IDLE; the divisor is unchanged. The counter saturates; it never wraps.
- Arithmetic: T8 is a 32-bit unsigned value. The +8 is computed at 33 bits before the shift, so there is no overflow.
- `autobaud_start` while busy is ignored. `autobaud_start` and `sw_div_wr` in the same cycle: the write is applied and start is ignored.
- `autobaud_done` and `autobaud_err` are never both asserted in the same cycle.
- The divisor changes only on the single applying edge, so there are no intermediate values.

Test Plan:
1. Reset → `baudrate_division`=216, busy/done/err=0. Hold rx=1 through and after reset → no edge is detected.
2. `sw_div_wr` with `sw_div`=1000 → 1000 one cycle later. Then `sw_div`=1 → clamped to 3.
3. `autobaud_start`, then drive 0x55 at 434 CLK/bit (8N1) → T8=3472, `baudrate_division`=216, a single `autobaud_done` pulse, busy drops that cycle.
4. Autobaud with 0x55 at 104 CLK/bit → divisor 51. With 0x55 at 8 CLK/bit → T8=64, div=3 accepted. With 0x55 at 4 CLK/bit → div=1, `autobaud_err`=1, divisor unchanged.
5. TIMEOUT=1000, `autobaud_start`, rx held high → err=1 and busy=0 exactly 1000 cycles after start. A subsequent `sw_div_wr` clears err.
6. Abort and async reset:
   - `sw_div_wr`=500 issued mid-MEASURE → divisor=500, busy=0, no done pulse, later edges ignored.
   - Separately, assert HRESET mid-MEASURE → all outputs return immediately to reset values.

Source files
------------

// File: rtl/uart_autobaud_ctrl_if.sv
// Configuration bus between the UART register block (master) and the
// autobaud/divisor controller (slave).
interface uart_autobaud_ctrl_if;
    logic        sw_div_wr;
    logic [31:0] sw_div;
    logic        autobaud_start;
    logic [31:0] baudrate_division;
    logic        autobaud_busy;
    logic        autobaud_done;
    logic        autobaud_err;

    modport master (
        output sw_div_wr,
        output sw_div,
        output autobaud_start,
        input  baudrate_division,
        input  autobaud_busy,
        input  autobaud_done,
        input  autobaud_err
    );

    modport slave (
        input  sw_div_wr,
        input  sw_div,
        input  autobaud_start,
        output baudrate_division,
        output autobaud_busy,
        output autobaud_done,
        output autobaud_err
    );
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// Owns the UART divisor word: loaded by software or measured from a received
// 0x55 character, never driven below MIN_DIV.
module uart_autobaud_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_DIV   = 32'd216,
    parameter logic [31:0] MIN_DIV     = 32'd3,
    parameter logic [31:0] TIMEOUT     = 32'd50000000
) (
    input  logic                 CLK,
    input  logic                 HRESET,
    input  logic                 rx,
    uart_autobaud_ctrl_if.slave  cfg
);

    typedef enum logic [1:0] {IDLE, WAIT_HIGH, ARM, MEASURE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev, fall;
    logic [31:0]            cyc_cnt, cyc_n;
    logic [2:0]             edge_cnt, edge_n;
    logic [31:0]            to_cnt, to_n, to_inc;
    logic                   timed_out;
    logic [31:0]            div_q, div_n;
    logic                   done_q, done_n;
    logic                   err_q, err_n;
    logic [31:0]            t8, meas_div, sw_clamp;
    logic [32:0]            meas_div33;
    logic                   meas_ok;

    // Synchronizer idles high so reset never fabricates a start-bit edge.
    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;

    // t8 includes the current cycle, so it equals eight bit times exactly.
    assign t8         = cyc_cnt + 32'd1;
    assign meas_div33 = ({1'b0, t8} + 33'd8) >> 4;
    assign meas_ok    = meas_div33 > {1'b0, MIN_DIV};
    assign meas_div   = meas_div33[31:0] - 32'd1;

    assign sw_clamp   = (cfg.sw_div < MIN_DIV) ? MIN_DIV : cfg.sw_div;

    assign to_inc     = (to_cnt >= TIMEOUT) ? to_cnt : to_cnt + 32'd1;
    assign timed_out  = to_inc >= TIMEOUT;

    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            edge_cnt <= '0;
            to_cnt   <= '0;
            div_q    <= RESET_DIV;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cyc_cnt  <= cyc_n;
            edge_cnt <= edge_n;
            to_cnt   <= to_n;
            div_q    <= div_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        edge_n  = edge_cnt;
        to_n    = to_cnt;
        div_n   = div_q;
        done_n  = 1'b0;
        err_n   = err_q;

        if (cfg.sw_div_wr) begin
            // Software write overrides and silently aborts any measurement.
            state_n = IDLE;
            div_n   = sw_clamp;
            err_n   = 1'b0;
        end else if (state == IDLE) begin
            if (cfg.autobaud_start) begin
                state_n = WAIT_HIGH;
                err_n   = 1'b0;
                cyc_n   = '0;
                edge_n  = '0;
                to_n    = '0;
            end
        end else begin
            to_n = to_inc;
            if (timed_out) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else begin
                unique case (state)
                    WAIT_HIGH: begin
                        if (rx_s) state_n = ARM;
                    end
                    ARM: begin
                        if (fall) begin
                            state_n = MEASURE;
                            cyc_n   = '0;
                            edge_n  = 3'd1;
                        end
                    end
                    MEASURE: begin
                        cyc_n = cyc_cnt + 32'd1;
                        if (fall) begin
                            if (edge_cnt == 3'd4) begin
                                state_n = IDLE;
                                if (meas_ok) begin
                                    div_n  = meas_div;
                                    done_n = 1'b1;
                                end else begin
                                    err_n  = 1'b1;
                                end
                            end else begin
                                edge_n = edge_cnt + 3'd1;
                            end
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    assign cfg.baudrate_division = div_q;
    assign cfg.autobaud_busy     = (state != IDLE);
    assign cfg.autobaud_done     = done_q;
    assign cfg.autobaud_err      = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed and randomized checks of the autobaud controller against a
// bit-period based reference model.
module tb_uart_autobaud_ctrl;

    localparam int MIN_DIV = 3;

    logic CLK = 1'b0;
    logic HRESET;
    logic rx;
    logic rx_to;

    uart_autobaud_ctrl_if ifc();
    uart_autobaud_ctrl_if ifc_to();

    uart_autobaud_ctrl dut (
        .CLK    (CLK),
        .HRESET (HRESET),
        .rx     (rx),
        .cfg    (ifc)
    );

    uart_autobaud_ctrl #(.TIMEOUT(32'd1000)) dut_to (
        .CLK    (CLK),
        .HRESET (HRESET),
        .rx     (rx_to),
        .cfg    (ifc_to)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_busy_bad = 0;
    int both_bad = 0;

    always @(negedge CLK) begin
        if (ifc.autobaud_done) begin
            done_cnt <= done_cnt + 1;
            if (ifc.autobaud_busy) done_busy_bad <= done_busy_bad + 1;
            if (ifc.autobaud_err)  both_bad <= both_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 8N1 frame of 0x55: start, LSB-first data, stop.
    function automatic logic frame_bit(input int i);
        logic [7:0] data;
        data = 8'h55;
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return data[i-1];
    endfunction

    task automatic send_bits(input int b, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            rx = frame_bit(i);
            repeat (b) @(negedge CLK);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge CLK) ifc.autobaud_start = 1'b1;
        @(negedge CLK) ifc.autobaud_start = 1'b0;
    endtask

    task automatic sw_write(input logic [31:0] v);
        @(negedge CLK);
        ifc.sw_div = v;
        ifc.sw_div_wr = 1'b1;
        @(negedge CLK) ifc.sw_div_wr = 1'b0;
    endtask

    longint model_div;

    // Model: 0x55 gives 4 falling edges after the start edge, spanning 8 bits.
    task automatic autobaud_run(input int b);
        longint t8, q;
        bit     ok;
        int     d0;
        t8 = 8 * b;
        q  = (t8 + 8) / 16;
        ok = (q - 1) >= MIN_DIV;
        pulse_start();
        repeat (3) @(negedge CLK);
        d0 = done_cnt;
        send_bits(b, 0, 10);
        repeat (6) @(negedge CLK);
        if (ok) model_div = q - 1;
        check($sformatf("ab%0d_done", b), 64'(done_cnt - d0), 64'(ok ? 1 : 0));
        check($sformatf("ab%0d_div", b), 64'(ifc.baudrate_division), 64'(model_div));
        check($sformatf("ab%0d_err", b), 64'(ifc.autobaud_err), 64'(!ok));
        check($sformatf("ab%0d_busy", b), 64'(ifc.autobaud_busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int busy_cycles;
        HRESET = 1'b0;
        rx = 1'b1;
        rx_to = 1'b1;
        ifc.sw_div_wr = 1'b0;  ifc.sw_div = '0;  ifc.autobaud_start = 1'b0;
        ifc_to.sw_div_wr = 1'b0; ifc_to.sw_div = '0; ifc_to.autobaud_start = 1'b0;
        model_div = 216;

        #23;
        check("rst_div", 64'(ifc.baudrate_division), 64'd216);
        check("rst_busy", 64'(ifc.autobaud_busy), 64'd0);
        check("rst_done", 64'(ifc.autobaud_done), 64'd0);
        check("rst_err", 64'(ifc.autobaud_err), 64'd0);
        @(negedge CLK) HRESET = 1'b1;
        repeat (8) @(negedge CLK);
        check("idle_div", 64'(ifc.baudrate_division), 64'd216);
        check("idle_busy", 64'(ifc.autobaud_busy), 64'd0);
        check("idle_done", 64'(done_cnt), 64'd0);

        sw_write(32'd1000);
        check("sw_1000", 64'(ifc.baudrate_division), 64'd1000);
        sw_write(32'd1);
        check("sw_clamp", 64'(ifc.baudrate_division), 64'd3);

        @(negedge CLK);
        ifc.sw_div = 32'd600;
        ifc.sw_div_wr = 1'b1;
        ifc.autobaud_start = 1'b1;
        @(negedge CLK);
        ifc.sw_div_wr = 1'b0;
        ifc.autobaud_start = 1'b0;
        check("wr_vs_start_div", 64'(ifc.baudrate_division), 64'd600);
        check("wr_vs_start_busy", 64'(ifc.autobaud_busy), 64'd0);
        model_div = 600;

        autobaud_run(434);
        autobaud_run(104);
        autobaud_run(8);
        autobaud_run(4);
        for (int i = 0; i < 6; i++) autobaud_run(int'($urandom_range(4, 300)));

        // Timeout on the instance configured with TIMEOUT=1000.
        @(negedge CLK) ifc_to.autobaud_start = 1'b1;
        @(negedge CLK) ifc_to.autobaud_start = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 2000 && ifc_to.autobaud_busy; k++) begin
            busy_cycles++;
            @(negedge CLK);
        end
        check("to_busy_cycles", 64'(busy_cycles), 64'd1000);
        check("to_err", 64'(ifc_to.autobaud_err), 64'd1);
        check("to_div", 64'(ifc_to.baudrate_division), 64'd216);
        @(negedge CLK);
        ifc_to.sw_div = 32'd77;
        ifc_to.sw_div_wr = 1'b1;
        @(negedge CLK) ifc_to.sw_div_wr = 1'b0;
        check("to_err_clear", 64'(ifc_to.autobaud_err), 64'd0);
        check("to_sw_div", 64'(ifc_to.baudrate_division), 64'd77);

        // Software write mid-measurement aborts without done or error.
        pulse_start();
        repeat (3) @(negedge CLK);
        d0 = done_cnt;
        send_bits(104, 0, 5);
        check("abort_busy_pre", 64'(ifc.autobaud_busy), 64'd1);
        sw_write(32'd500);
        check("abort_div", 64'(ifc.baudrate_division), 64'd500);
        check("abort_busy", 64'(ifc.autobaud_busy), 64'd0);
        send_bits(104, 5, 10);
        repeat (6) @(negedge CLK);
        check("abort_done", 64'(done_cnt - d0), 64'd0);
        check("abort_err", 64'(ifc.autobaud_err), 64'd0);
        check("abort_div_hold", 64'(ifc.baudrate_division), 64'd500);

        // Asynchronous reset mid-measurement.
        pulse_start();
        repeat (3) @(negedge CLK);
        send_bits(50, 0, 4);
        rx = 1'b0;
        #3 HRESET = 1'b0;
        #1;
        check("arst_div", 64'(ifc.baudrate_division), 64'd216);
        check("arst_busy", 64'(ifc.autobaud_busy), 64'd0);
        check("arst_done", 64'(ifc.autobaud_done), 64'd0);
        check("arst_err", 64'(ifc.autobaud_err), 64'd0);
        rx = 1'b1;
        @(negedge CLK) HRESET = 1'b1;
        repeat (4) @(negedge CLK);

        check("done_with_busy", 64'(done_busy_bad), 64'd0);
        check("done_with_err", 64'(both_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
